i2c_init_sequencer: RTL and testbench
=====================================

// Module: i2c_init_sequencer
// PURPOSE
//  Upstream command source for the I2C DAC register writer. Walks an external init table of
//  {reg_addr,data} entries after power-up and issues one write command per entry. Supports
//  inline delays, end markers, NACK/timeout retry and a sticky done/error status.
//  Sits between top-level start/config logic and the I2C write engine.
// PARAMETERS
//  NUM_ENTRIES  16      table depth; walk stops at last index if no end marker
//  IDX_W        4       width of tbl_index/err_index, = clog2(NUM_ENTRIES)
//  DEV_ADDR     7'h10   7-bit I2C device address driven on every command
//  PWR_WAIT     1000    clk cycles waited after start before first fetch
//  DELAY_UNIT   1000    clk cycles per count of a delay entry
//  RETRY_MAX    2       re-issues of one entry after first failure (3 attempts total)
//  RETRY_GAP    256     idle clk cycles between failure and re-issue
//  TIMEOUT_CYC  65535   max cycles from cmd accept to wr_done; expiry = failure
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous, active-high reset
//  start         in   1      level; begins sequence when in IDLE/DONE/ERROR
//  tbl_index     out  IDX_W  table read address
//  tbl_entry     in   16     {reg_addr[15:8],data[7:0]}, valid 1 cycle after tbl_index
//  cmd_valid     out  1      write command pending
//  cmd_ready     in   1      writer accepts command when high with cmd_valid
//  cmd_i2c_addr  out  7      = DEV_ADDR
//  cmd_reg_addr  out  8      register address of current entry
//  cmd_data      out  8      data byte of current entry
//  wr_done       in   1      1-cycle pulse: write finished
//  wr_ack_ok     in   1      sampled with wr_done; 1 = all bytes ACKed
//  busy          out  1      high in every state except IDLE/DONE/ERROR
//  init_done     out  1      sticky, table completed without error
//  init_err      out  1      sticky, an entry exhausted its retries
//  err_index     out  IDX_W  index of failing entry, valid while init_err
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (cmd_i2c_addr/cmd_reg_addr/cmd_data = 0); counters cleared.
//   rst mid-sequence aborts immediately; cmd_valid drops next edge; any later wr_done is ignored.
//  States: IDLE -> PWR_WAIT -> FETCH -> DECODE -> {ISSUE | DELAY | DONE}; ISSUE -> WAIT_WR;
//   WAIT_WR -> NEXT (ok) | GAP (fail, retries left) | ERROR; GAP -> ISSUE; DELAY -> NEXT;
//   NEXT -> FETCH (index+1) | DONE (index == NUM_ENTRIES-1).
//  start in IDLE/DONE/ERROR: clears init_done/init_err/err_index, index=0, enter PWR_WAIT for
//   exactly PWR_WAIT cycles. start while busy is ignored.
//  FETCH drives tbl_index; DECODE registers tbl_entry (1-cycle ROM latency).
//  Decode: reg 8'hFE = end marker -> DONE, no command issued. reg 8'hFF = delay: wait
//   data*DELAY_UNIT cycles (data=0 -> zero-length, straight to NEXT). Any other reg -> ISSUE.
//  ISSUE: cmd_valid=1 with fields stable until cycle where cmd_ready=1; cmd_valid low next cycle.
//  WAIT_WR: timeout counter starts at accept. wr_done&wr_ack_ok -> success. wr_done&!wr_ack_ok
//   or counter reaching TIMEOUT_CYC -> failure. wr_done outside WAIT_WR ignored.
//  Retry count resets per entry; after RETRY_MAX failed re-issues -> ERROR, err_index=index.
//  DONE: init_done=1. ERROR: init_err=1. Both hold until next start or rst.
//  Delay/wait counters 32-bit internally; no wrap for data*DELAY_UNIT <= 2^32-1.
// TESTING
//  T1 table {4700/02, 0155, FE00}, writer acks -> 2 cmds (47/02, 01/55), addr 10, init_done=1.
//  T2 entry 0 gets wr_ack_ok=0 twice then ok -> 3 issues of entry 0, init_done=1, init_err=0.
//  T3 entry 1 always NACKs -> 3 issues, each 256-cycle gap, init_err=1, err_index=1, busy=0.
//  T4 entry FF03 -> next cmd_valid rises >=3000 cycles after delay decode; FF00 -> no wait.
//  T5 cmd_ready held low 50 cycles -> cmd_valid/fields stable throughout; timeout -> retry.
//  T6 rst asserted in WAIT_WR, stray wr_done after -> all outputs 0, state IDLE, no restart.

Source files
------------

// File: rtl/i2c_init_sequencer_if.sv
// Sequencer bus: start/status, init-table read port, write-command handshake and write-done report.
// master = sequencer side; slave = start logic, table ROM and I2C write engine.
interface i2c_init_sequencer_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic [IDX_W-1:0] tbl_index;
    logic [15:0]      tbl_entry;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [6:0]       cmd_i2c_addr;
    logic [7:0]       cmd_reg_addr;
    logic [7:0]       cmd_data;
    logic             wr_done;
    logic             wr_ack_ok;
    logic             busy;
    logic             init_done;
    logic             init_err;
    logic [IDX_W-1:0] err_index;

    modport master (
        input  start, tbl_entry, cmd_ready, wr_done, wr_ack_ok,
        output tbl_index, cmd_valid, cmd_i2c_addr, cmd_reg_addr, cmd_data,
        output busy, init_done, init_err, err_index
    );

    modport slave (
        output start, tbl_entry, cmd_ready, wr_done, wr_ack_ok,
        input  tbl_index, cmd_valid, cmd_i2c_addr, cmd_reg_addr, cmd_data,
        input  busy, init_done, init_err, err_index
    );
endinterface

// File: rtl/i2c_init_sequencer.sv
// Walks an init table after a power-up wait and issues one I2C write per entry, with delays, end marker, retries.
// Table read has 1-cycle latency; cmd_valid holds with stable fields until cmd_ready, retried on NACK/timeout.
module i2c_init_sequencer #(
    parameter int         NUM_ENTRIES = 16,
    parameter int         IDX_W       = 4,
    parameter logic [6:0] DEV_ADDR    = 7'h10,
    parameter int         PWR_WAIT    = 1000,
    parameter int         DELAY_UNIT  = 1000,
    parameter int         RETRY_MAX   = 2,
    parameter int         RETRY_GAP   = 256,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    i2c_init_sequencer_if.master io_bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_PWR_WAIT, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_WR,
        S_GAP, S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;

    localparam logic [31:0]      PWR_LAST     = 32'(PWR_WAIT - 1);
    localparam logic [31:0]      GAP_LAST     = 32'(RETRY_GAP - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0]      DELAY_MULT   = 32'(DELAY_UNIT);
    localparam logic [7:0]       RETRY_LIM    = 8'(RETRY_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_ENTRIES - 1);

    state_t           r_state,     w_state_nxt;
    logic [31:0]      r_cnt,       w_cnt_nxt;
    logic [31:0]      r_delay,     w_delay_nxt;
    logic [IDX_W-1:0] r_index,     w_index_nxt;
    logic [IDX_W-1:0] r_err_index, w_err_index_nxt;
    logic [7:0]       r_retry,     w_retry_nxt;
    logic [6:0]       r_i2c_addr,  w_i2c_addr_nxt;
    logic [7:0]       r_reg_addr,  w_reg_addr_nxt;
    logic [7:0]       r_data,      w_data_nxt;
    logic [31:0]      w_delay_len;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_delay     <= '0;
            r_index     <= '0;
            r_err_index <= '0;
            r_retry     <= '0;
            r_i2c_addr  <= '0;
            r_reg_addr  <= '0;
            r_data      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_delay     <= w_delay_nxt;
            r_index     <= w_index_nxt;
            r_err_index <= w_err_index_nxt;
            r_retry     <= w_retry_nxt;
            r_i2c_addr  <= w_i2c_addr_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_data      <= w_data_nxt;
        end
    end

    always_comb begin
        // r_cnt only runs in timed states; every other state parks it at zero so entry starts from 0
        w_state_nxt     = r_state;
        w_cnt_nxt       = '0;
        w_delay_nxt     = r_delay;
        w_index_nxt     = r_index;
        w_err_index_nxt = r_err_index;
        w_retry_nxt     = r_retry;
        w_i2c_addr_nxt  = r_i2c_addr;
        w_reg_addr_nxt  = r_reg_addr;
        w_data_nxt      = r_data;
        w_delay_len     = 32'(io_bus.tbl_entry[7:0]) * DELAY_MULT;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (io_bus.start) begin
                    w_state_nxt     = S_PWR_WAIT;
                    w_index_nxt     = '0;
                    w_err_index_nxt = '0;
                    w_retry_nxt     = '0;
                end
            end
            S_PWR_WAIT: begin
                w_cnt_nxt = r_cnt + 32'd1;
                if (r_cnt == PWR_LAST) begin
                    w_state_nxt = S_FETCH;
                    w_cnt_nxt   = '0;
                end
            end
            S_FETCH: w_state_nxt = S_DECODE;
            S_DECODE: begin
                w_i2c_addr_nxt = DEV_ADDR;
                w_reg_addr_nxt = io_bus.tbl_entry[15:8];
                w_data_nxt     = io_bus.tbl_entry[7:0];
                w_delay_nxt    = w_delay_len;
                w_retry_nxt    = '0;
                if (io_bus.tbl_entry[15:8] == 8'hFE)
                    w_state_nxt = S_DONE;
                else if (io_bus.tbl_entry[15:8] == 8'hFF)
                    w_state_nxt = (io_bus.tbl_entry[7:0] == 8'h00) ? S_NEXT : S_DELAY;
                else
                    w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (io_bus.cmd_ready)
                    w_state_nxt = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                w_cnt_nxt = r_cnt + 32'd1;
                if (io_bus.wr_done && io_bus.wr_ack_ok) begin
                    w_state_nxt = S_NEXT;
                end else if (io_bus.wr_done || (r_cnt == TIMEOUT_LAST)) begin
                    if (r_retry == RETRY_LIM) begin
                        w_state_nxt     = S_ERROR;
                        w_err_index_nxt = r_index;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_retry_nxt = r_retry + 8'd1;
                    end
                end
                if (w_state_nxt != S_WAIT_WR)
                    w_cnt_nxt = '0;
            end
            S_GAP: begin
                w_cnt_nxt = r_cnt + 32'd1;
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = S_ISSUE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DELAY: begin
                w_cnt_nxt = r_cnt + 32'd1;
                if (r_cnt == r_delay - 32'd1) begin
                    w_state_nxt = S_NEXT;
                    w_cnt_nxt   = '0;
                end
            end
            S_NEXT: begin
                if (r_index == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_index_nxt = r_index + IDX_W'(1);
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign io_bus.tbl_index    = r_index;
    assign io_bus.cmd_valid    = (r_state == S_ISSUE);
    assign io_bus.cmd_i2c_addr = r_i2c_addr;
    assign io_bus.cmd_reg_addr = r_reg_addr;
    assign io_bus.cmd_data     = r_data;
    assign io_bus.busy         = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
    assign io_bus.init_done    = (r_state == S_DONE);
    assign io_bus.init_err     = (r_state == S_ERROR);
    assign io_bus.err_index    = r_err_index;
endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench: table ROM and scripted I2C writer around the sequencer; cycle-exact timing checks.
module tb_i2c_init_sequencer;
    logic clk = 1'b0;
    logic rst;
    i2c_init_sequencer_if #(.IDX_W(4)) bus ();

    i2c_init_sequencer #(.TIMEOUT_CYC(500)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] rom [16];
    always @(posedge clk) bus.tbl_entry <= rom[bus.tbl_index];

    // Writer script: response per accepted command of the current test (1 ack, 0 nack, 2 silent)
    int          resp_tbl [8];
    int          rdy_wait;
    int          acc_base, log_base, rise_base, done_base;
    int          stray_cnt;
    logic [22:0] log_q [$];
    int          acc_q [$];
    int          rise_q [$];
    int          done_q [$];
    int          n_pass = 0;
    int          n_total = 0;
    int          start_cyc;

    initial begin
        int  wp, rdy_cnt, done_wait, resp, ri, stray_seen;
        bit  prev_vld;
        wp = 0; rdy_cnt = 0; done_wait = 0; resp = 1; stray_seen = 0; prev_vld = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.wr_done   = 1'b0;
        bus.wr_ack_ok = 1'b0;
        forever begin
            @(negedge clk);
            bus.wr_done   = 1'b0;
            bus.wr_ack_ok = 1'b0;
            if (bus.cmd_valid && !prev_vld) rise_q.push_back(cyc);
            prev_vld = bus.cmd_valid;
            if (stray_cnt != stray_seen) begin
                bus.wr_done   = 1'b1;
                bus.wr_ack_ok = 1'b1;
                stray_seen    = stray_cnt;
            end else begin
                case (wp)
                    0: if (bus.cmd_valid) begin
                        if ((acc_q.size() == acc_base) && (rdy_cnt < rdy_wait)) begin
                            rdy_cnt++;
                        end else begin
                            bus.cmd_ready = 1'b1;
                            log_q.push_back({bus.cmd_i2c_addr, bus.cmd_reg_addr, bus.cmd_data});
                            acc_q.push_back(cyc);
                            rdy_cnt = 0;
                            wp = 1;
                        end
                    end
                    1: begin
                        bus.cmd_ready = 1'b0;
                        ri   = acc_q.size() - 1 - acc_base;
                        resp = (ri < 8) ? resp_tbl[ri] : 1;
                        if (resp == 2) wp = 0;
                        else begin done_wait = 3; wp = 2; end
                    end
                    2: begin
                        if (done_wait > 1) begin
                            done_wait--;
                        end else begin
                            bus.wr_done   = 1'b1;
                            bus.wr_ack_ok = (resp == 1);
                            done_q.push_back(cyc);
                            wp = 0;
                        end
                    end
                    default: wp = 0;
                endcase
            end
        end
    end

    function automatic logic [22:0] log_at(input int i);
        return (i < log_q.size()) ? log_q[i] : 23'bx;
    endfunction
    function automatic int rise_at(input int i);
        return (i < rise_q.size()) ? rise_q[i] : -100000;
    endfunction
    function automatic int done_at(input int i);
        return (i < done_q.size()) ? done_q[i] : 100000;
    endfunction
    function automatic int acc_at(input int i);
        return (i < acc_q.size()) ? acc_q[i] : 100000;
    endfunction

    task automatic load_rom(input logic [15:0] e0, e1, e2, e3, e4);
        for (int i = 0; i < 16; i++) rom[i] = 16'hFE00;
        rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3; rom[4] = e4;
        resp_tbl  = '{1, 1, 1, 1, 1, 1, 1, 1};
        rdy_wait  = 0;
        acc_base  = acc_q.size();
        log_base  = log_q.size();
        rise_base = rise_q.size();
        done_base = done_q.size();
    endtask

    task automatic start_seq();
        @(negedge clk);
        bus.start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (!bus.busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++; if ({bus.cmd_valid, bus.busy, bus.init_done, bus.init_err} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {bus.cmd_valid, bus.busy, bus.init_done, bus.init_err}); else n_pass++;
        n_total++; if ({bus.tbl_index, bus.err_index} !== 8'h00) $display("FAIL reset_idx: got %h want 00", {bus.tbl_index, bus.err_index}); else n_pass++;
        n_total++; if ({bus.cmd_i2c_addr, bus.cmd_reg_addr, bus.cmd_data} !== 23'h0) $display("FAIL reset_fields: got %h want 0", {bus.cmd_i2c_addr, bus.cmd_reg_addr, bus.cmd_data}); else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        load_rom(16'h4702, 16'h0155, 16'hFE00, 16'hFE00, 16'hFE00);
        start_seq();
        wait_idle(5000, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL t1_finish: busy never dropped"); else n_pass++;
        n_total++; if (log_q.size() - log_base !== 2) $display("FAIL t1_count: got %0d want 2", log_q.size() - log_base); else n_pass++;
        n_total++; if (log_at(log_base) !== {7'h10, 8'h47, 8'h02}) $display("FAIL t1_cmd0: got %h want %h", log_at(log_base), {7'h10, 8'h47, 8'h02}); else n_pass++;
        n_total++; if (log_at(log_base + 1) !== {7'h10, 8'h01, 8'h55}) $display("FAIL t1_cmd1: got %h want %h", log_at(log_base + 1), {7'h10, 8'h01, 8'h55}); else n_pass++;
        n_total++; if ({bus.init_done, bus.init_err} !== 2'b10) $display("FAIL t1_status: got %b want 10", {bus.init_done, bus.init_err}); else n_pass++;
        n_total++; if (rise_at(rise_base) - start_cyc !== 1003) $display("FAIL t1_pwr_wait: got %0d want 1003", rise_at(rise_base) - start_cyc); else n_pass++;
    endtask

    task automatic test_nack_retry();
        bit ok;
        load_rom(16'h1122, 16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00);
        resp_tbl[0] = 0;
        resp_tbl[1] = 0;
        start_seq();
        repeat (500) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(5000, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL t2_finish: busy never dropped"); else n_pass++;
        n_total++; if (rise_at(rise_base) - start_cyc !== 1003) $display("FAIL t2_start_ignored: got %0d want 1003", rise_at(rise_base) - start_cyc); else n_pass++;
        n_total++; if (log_q.size() - log_base !== 3) $display("FAIL t2_issues: got %0d want 3", log_q.size() - log_base); else n_pass++;
        n_total++; if (log_at(log_base + 2) !== {7'h10, 8'h11, 8'h22}) $display("FAIL t2_cmd2: got %h want %h", log_at(log_base + 2), {7'h10, 8'h11, 8'h22}); else n_pass++;
        n_total++; if ({bus.init_done, bus.init_err} !== 2'b10) $display("FAIL t2_status: got %b want 10", {bus.init_done, bus.init_err}); else n_pass++;
    endtask

    task automatic test_retry_exhaust();
        bit ok;
        load_rom(16'h4702, 16'h0155, 16'hFE00, 16'hFE00, 16'hFE00);
        resp_tbl[1] = 0; resp_tbl[2] = 0; resp_tbl[3] = 0;
        start_seq();
        wait_idle(5000, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL t3_finish: busy never dropped"); else n_pass++;
        n_total++; if (log_q.size() - log_base !== 4) $display("FAIL t3_issues: got %0d want 4", log_q.size() - log_base); else n_pass++;
        n_total++; if (log_at(log_base + 3) !== {7'h10, 8'h01, 8'h55}) $display("FAIL t3_cmd3: got %h want %h", log_at(log_base + 3), {7'h10, 8'h01, 8'h55}); else n_pass++;
        n_total++; if (rise_at(rise_base + 2) - done_at(done_base + 1) !== 257) $display("FAIL t3_gap1: got %0d want 257", rise_at(rise_base + 2) - done_at(done_base + 1)); else n_pass++;
        n_total++; if (rise_at(rise_base + 3) - done_at(done_base + 2) !== 257) $display("FAIL t3_gap2: got %0d want 257", rise_at(rise_base + 3) - done_at(done_base + 2)); else n_pass++;
        n_total++; if ({bus.busy, bus.init_done, bus.init_err} !== 3'b001) $display("FAIL t3_status: got %b want 001", {bus.busy, bus.init_done, bus.init_err}); else n_pass++;
        n_total++; if (bus.err_index !== 4'd1) $display("FAIL t3_err_index: got %0d want 1", bus.err_index); else n_pass++;
    endtask

    task automatic test_delay();
        bit ok;
        load_rom(16'hFF03, 16'h1234, 16'hFF00, 16'h5678, 16'hFE00);
        start_seq();
        n_total++; if ({bus.init_err, bus.err_index} !== 5'h00) $display("FAIL t4_err_cleared: got %h want 00", {bus.init_err, bus.err_index}); else n_pass++;
        wait_idle(10000, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL t4_finish: busy never dropped"); else n_pass++;
        n_total++; if (log_q.size() - log_base !== 2) $display("FAIL t4_count: got %0d want 2", log_q.size() - log_base); else n_pass++;
        n_total++; if (rise_at(rise_base) - start_cyc !== 4006) $display("FAIL t4_delay3: got %0d want 4006", rise_at(rise_base) - start_cyc); else n_pass++;
        n_total++; if (rise_at(rise_base + 1) - done_at(done_base) !== 7) $display("FAIL t4_delay0: got %0d want 7", rise_at(rise_base + 1) - done_at(done_base)); else n_pass++;
        n_total++; if (log_at(log_base + 1) !== {7'h10, 8'h56, 8'h78}) $display("FAIL t4_cmd1: got %h want %h", log_at(log_base + 1), {7'h10, 8'h56, 8'h78}); else n_pass++;
    endtask

    task automatic test_backpressure_timeout();
        bit ok;
        int bad;
        load_rom(16'hABCD, 16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00);
        rdy_wait    = 50;
        resp_tbl[0] = 2;
        start_seq();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.cmd_valid) begin ok = 1'b1; break; end
        end
        n_total++; if (ok !== 1'b1) $display("FAIL t5_valid_seen: cmd_valid never rose"); else n_pass++;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if ({bus.cmd_valid, bus.cmd_i2c_addr, bus.cmd_reg_addr, bus.cmd_data} !== {1'b1, 7'h10, 8'hAB, 8'hCD}) bad++;
            @(negedge clk);
        end
        n_total++; if (bad !== 0) $display("FAIL t5_stable: got %0d unstable cycles want 0", bad); else n_pass++;
        wait_idle(5000, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL t5_finish: busy never dropped"); else n_pass++;
        n_total++; if (log_q.size() - log_base !== 2) $display("FAIL t5_issues: got %0d want 2", log_q.size() - log_base); else n_pass++;
        n_total++; if (rise_at(rise_base + 1) - acc_at(acc_base) !== 757) $display("FAIL t5_timeout: got %0d want 757", rise_at(rise_base + 1) - acc_at(acc_base)); else n_pass++;
        n_total++; if ({bus.init_done, bus.init_err} !== 2'b10) $display("FAIL t5_status: got %b want 10", {bus.init_done, bus.init_err}); else n_pass++;
    endtask

    task automatic test_reset_abort();
        bit ok;
        load_rom(16'h4702, 16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00);
        resp_tbl[0] = 2;
        start_seq();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (acc_q.size() > acc_base) begin ok = 1'b1; break; end
        end
        n_total++; if (ok !== 1'b1) $display("FAIL t6_accept: command never accepted"); else n_pass++;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stray_cnt++;
        repeat (1200) @(negedge clk);
        n_total++; if ({bus.cmd_valid, bus.busy, bus.init_done, bus.init_err} !== 4'b0) $display("FAIL t6_flags: got %b want 0000", {bus.cmd_valid, bus.busy, bus.init_done, bus.init_err}); else n_pass++;
        n_total++; if ({bus.cmd_i2c_addr, bus.cmd_reg_addr, bus.cmd_data, bus.tbl_index, bus.err_index} !== 31'h0) $display("FAIL t6_outputs: got %h want 0", {bus.cmd_i2c_addr, bus.cmd_reg_addr, bus.cmd_data, bus.tbl_index, bus.err_index}); else n_pass++;
        n_total++; if (rise_q.size() - rise_base !== 1) $display("FAIL t6_no_restart: got %0d rises want 1", rise_q.size() - rise_base); else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        stray_cnt = 0;
        rdy_wait  = 0;
        acc_base  = 0; log_base = 0; rise_base = 0; done_base = 0;
        resp_tbl  = '{1, 1, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 16; i++) rom[i] = 16'hFE00;
        test_reset();
        test_basic();
        test_nack_retry();
        test_retry_exhaust();
        test_delay();
        test_backpressure_timeout();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
